// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave serial front end for the SPI memory slave
//
// Deserialises MOSI into {opcode[1:0], payload} command words for the on-chip
// RAM and, for read-data commands, serialises the RAM response back on MISO.
//
// Ports:
//   clk       SPI serial clock, all logic on posedge
//   rst       synchronous active-high reset
//   SS_n      slave select, active low; high aborts any frame in progress
//   MOSI      master-out serial data
//   MISO      slave-out serial data (registered, MSB first)
//   rx_data   last assembled command word
//   rx_valid  one-cycle strobe when rx_data updates
//   tx_data   RAM read data
//   tx_valid  RAM read data valid (may stay high after a read)
module spi_slave_if #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam int RX_W  = DATA_W + 2;
    localparam int CNT_W = $clog2(RX_W);
    localparam int TXC_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RX_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  bit_cnt;
    logic [RX_W-2:0]   shift;
    logic              word_done;
    logic              rd_addr_seen;
    // Read-response sequencing: rd_skip covers the rx_valid cycle (tx_valid
    // there may be stale from an earlier read), rd_arm waits for fresh data.
    logic              rd_skip;
    logic              rd_arm;
    logic              tx_busy;
    logic [TXC_W-1:0]  tx_cnt;
    logic [DATA_W-1:0] tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    next_state = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    next_state = IDLE;
                end else if (!MOSI) begin
                    next_state = WRITE;
                end else if (rd_addr_seen) begin
                    next_state = READ_DATA;
                end else begin
                    next_state = READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            bit_cnt      <= '0;
            shift        <= '0;
            word_done    <= 1'b0;
            rd_addr_seen <= 1'b0;
            rd_skip      <= 1'b0;
            rd_arm       <= 1'b0;
            tx_busy      <= 1'b0;
            tx_cnt       <= '0;
            tx_shift     <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || state == IDLE || state == CHK_CMD) begin
                // Abort or between frames: drop any partial word or response.
                MISO      <= 1'b0;
                bit_cnt   <= '0;
                shift     <= '0;
                word_done <= 1'b0;
                rd_skip   <= 1'b0;
                rd_arm    <= 1'b0;
                tx_busy   <= 1'b0;
                tx_cnt    <= '0;
            end else begin
                if (!word_done) begin
                    shift   <= {shift[RX_W-3:0], MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data   <= {shift, MOSI};
                        rx_valid  <= 1'b1;
                        word_done <= 1'b1;
                        bit_cnt   <= '0;
                        if (state == READ_ADD) begin
                            rd_addr_seen <= 1'b1;
                        end
                        if (state == READ_DATA) begin
                            rd_addr_seen <= 1'b0;
                            rd_skip      <= 1'b1;
                        end
                    end
                end

                MISO <= 1'b0;
                if (rd_skip) begin
                    rd_skip <= 1'b0;
                    rd_arm  <= 1'b1;
                end else if (rd_arm) begin
                    if (tx_valid) begin
                        rd_arm   <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_shift <= tx_data;
                        tx_cnt   <= TXC_W'(DATA_W - 2);
                        MISO     <= tx_data[DATA_W-1];
                    end
                end else if (tx_busy) begin
                    MISO <= tx_shift[tx_cnt];
                    if (tx_cnt == '0) begin
                        tx_busy <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - self-checking bench for spi_slave_if
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: whether a read address has been taken, last word seen.
    bit         model_seen = 1'b0;
    logic [9:0] model_rx   = '0;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // One SPI frame. abort_at: word bit index whose edge also sees SS_n high
    // (-1 = none). delay: cycles after N+1 before fresh tx_valid. stale: hold
    // tx_valid high with 8'h11 during cycle N. rst_at: cycle offset from N at
    // whose ending edge rst is applied (-1 = none).
    task automatic run_frame(input bit cmd, input logic [9:0] word, input int abort_at,
                             input int delay, input logic [7:0] txd, input bit stale,
                             input int rst_at);
        bit exp_read;
        bit aborted;
        int lat;
        logic exp_miso;
        exp_read = cmd && model_seen;
        aborted  = 1'b0;
        @(negedge clk);
        SS_n     = 1'b0;
        MOSI     = 1'($urandom);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        @(negedge clk);
        MOSI = cmd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (rx_valid !== 1'b0 || MISO !== 1'b0) begin
                miscompares++;
                $display("FAIL word_bit%0d: rx_valid=%b MISO=%b, required 0 0", i, rx_valid, MISO);
            end
            MOSI = word[9-i];
            if (i == abort_at) begin
                SS_n    = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (i == 9 && stale) begin
                tx_valid = 1'b1;
                tx_data  = 8'h11;
            end
        end
        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                vectors++;
                if (rx_valid !== 1'b0 || MISO !== 1'b0 || rx_data !== model_rx) begin
                    miscompares++;
                    $display("FAIL abort: rx_valid=%b MISO=%b rx_data=%h, required 0 0 %h",
                             rx_valid, MISO, rx_data, model_rx);
                end
            end
            return;
        end
        if (cmd) model_seen = !model_seen;
        model_rx = word;
        lat = 1 + delay;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            vectors++;
            if (rx_valid !== (c == 0)) begin
                miscompares++;
                $display("FAIL rx_valid_c%0d: got %b, required %b", c, rx_valid, c == 0);
            end
            if (c == 0) begin
                vectors++;
                if (rx_data !== word) begin
                    miscompares++;
                    $display("FAIL rx_data: got %h, required %h", rx_data, word);
                end
            end
            exp_miso = (exp_read && c >= lat + 1 && c <= lat + 8) ? txd[7-(c-lat-1)] : 1'b0;
            vectors++;
            if (MISO !== exp_miso) begin
                miscompares++;
                $display("FAIL miso_c%0d: got %b, required %b (txd=%h)", c, MISO, exp_miso, txd);
            end
            if (c == rst_at) begin
                rst  = 1'b1;
                SS_n = 1'b1;
                @(negedge clk);
                vectors++;
                if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
                    miscompares++;
                    $display("FAIL mid_reset: MISO=%b rx_valid=%b rx_data=%h, required 0 0 000",
                             MISO, rx_valid, rx_data);
                end
                rst        = 1'b0;
                model_seen = 1'b0;
                model_rx   = '0;
                return;
            end
            MOSI = 1'($urandom);
            if (c >= lat) begin
                tx_valid = 1'b1;
                tx_data  = txd;
            end else begin
                tx_valid = (c == 0) ? stale : 1'b0;
                tx_data  = (c == 0 && stale) ? 8'h11 : 8'($urandom);
            end
        end
        @(negedge clk);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            miscompares++;
            $display("FAIL reset: MISO=%b rx_valid=%b rx_data=%h, required 0 0 000",
                     MISO, rx_valid, rx_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        run_frame(1'b0, 10'h005, -1, 0, 8'h00, 1'b0, -1);
        run_frame(1'b0, 10'h1AA, -1, 0, 8'h00, 1'b0, -1);
    endtask

    task automatic test_read();
        run_frame(1'b1, 10'h205, -1, 0, 8'h00, 1'b0, -1);
        run_frame(1'b1, 10'h300, -1, 0, 8'hA5, 1'b0, -1);
    endtask

    task automatic test_stale();
        run_frame(1'b1, 10'h207, -1, 0, 8'h00, 1'b0, -1);
        run_frame(1'b1, 10'h300, -1, 0, 8'h3C, 1'b1, -1);
    endtask

    task automatic test_abort();
        run_frame(1'b0, 10'h155, 6, 0, 8'h00, 1'b0, -1);
        run_frame(1'b0, 10'h0F3, -1, 0, 8'h00, 1'b0, -1);
        run_frame(1'b0, 10'h2AA, 9, 0, 8'h00, 1'b0, -1);
        run_frame(1'b1, 10'h211, -1, 0, 8'h00, 1'b0, -1);
        run_frame(1'b1, 10'h300, 3, 0, 8'h00, 1'b0, -1);
        run_frame(1'b1, 10'h300, -1, 1, 8'h96, 1'b0, -1);
    endtask

    task automatic test_reset_mid_read();
        run_frame(1'b1, 10'h233, -1, 0, 8'h00, 1'b0, -1);
        run_frame(1'b1, 10'h300, -1, 0, 8'hE7, 1'b0, 4);
        run_frame(1'b1, 10'h244, -1, 0, 8'hFF, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_frame(1'($urandom), 10'($urandom),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
                      int'($urandom_range(0, 2)), 8'($urandom), 1'($urandom), -1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stale();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
